// File: rtl/shift_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_deserializer: serial-to-parallel byte assembler with valid/ready   |
// | output; optional even-parity check enabled by macro PARITY_CHECK_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module shift_deserializer (
  input  logic       clk,
  input  logic       reset,
  input  logic       sin,
  input  logic       sin_valid,
  input  logic       msb_first,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       overrun,
  output logic       parity_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
`ifdef PARITY_CHECK_EN
  localparam logic [1:0] PARITY  = 2'd2;
`endif

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       order_q, order_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       overrun_q, overrun_d;

  logic       bit_order;
  logic [7:0] shifted;
  logic       word_done;
  logic [7:0] word_val;

  // The first bit of a word takes its order straight from the pin.
  assign bit_order = (state_q == IDLE) ? msb_first : order_q;
  assign shifted   = bit_order ? {shreg_q[6:0], sin} : {sin, shreg_q[7:1]};

`ifdef PARITY_CHECK_EN
  logic parity_err_q, parity_err_d;
  logic word_perr;

  assign word_done = sin_valid && (state_q == PARITY);
  assign word_val  = shreg_q;
  assign word_perr = (^shreg_q) ^ sin;
`else
  assign word_done = sin_valid && (state_q == COLLECT) && (cnt_q == 3'd7);
  assign word_val  = shifted;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      shreg_q      <= 8'h00;
      order_q      <= 1'b0;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      order_q      <= order_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
`ifdef PARITY_CHECK_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (sin_valid) begin
      case (state_q)
        IDLE:    state_d = COLLECT;
        COLLECT: begin
          if (cnt_q == 3'd7) begin
`ifdef PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = IDLE;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    order_d      = order_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = 1'b0;
`ifdef PARITY_CHECK_EN
    parity_err_d = parity_err_q;
`endif

    if (sin_valid) begin
      order_d = bit_order;
`ifdef PARITY_CHECK_EN
      if (state_q != PARITY) begin
        shreg_d = shifted;
        cnt_d   = cnt_q + 3'd1;
      end
`else
      shreg_d = shifted;
      cnt_d   = cnt_q + 3'd1;
`endif
    end

    if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end

    // A finished word is only kept if the output slot is free or draining now.
    if (word_done) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = word_val;
        dout_valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
        parity_err_d = word_perr;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_shift_deserializer: vector table plus directed sequences, scoreboard  |
// | checks every delivered word.                                             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_shift_deserializer;

`ifdef PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sin = 1'b0;
  logic       sin_valid = 1'b0;
  logic       msb_first = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       overrun;
  logic       parity_err;

  int checks = 0;
  int passes = 0;

  logic [8:0] sb_q[$];

  shift_deserializer dut (
    .clk        (clk),
    .reset      (reset),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .msb_first  (msb_first),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: a delivery happens on the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (!reset && dout_valid && dout_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL sb_unexpected: got word %0h expected none", dout);
      end else begin
        chk("sb_word", {parity_err, dout}, sb_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    sin_valid = 1'b0;
    repeat (gap) step();
    sin       = b;
    sin_valid = 1'b1;
    step();
    sin_valid = 1'b0;
  endtask

  // seq[7] is the first bit on the wire; last_ready is applied on the completing bit.
  task automatic send_seq(input logic msb, input logic [7:0] seq, input int gap,
                          input bit toggle, input logic last_ready, input logic pflip);
    msb_first = msb;
    for (int i = 0; i < 8; i++) begin
      if (toggle && i > 0) msb_first = ~msb_first;
      if (!PAR && i == 7) dout_ready = last_ready;
      send_bit(seq[7-i], gap);
    end
    if (PAR) begin
      dout_ready = last_ready;
      send_bit((^seq) ^ pflip, gap);
    end
  endtask

  typedef struct {
    logic       msb;
    logic [7:0] seq;
    int         gap;
    bit         toggle;
    logic       pflip;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic exp_perr;

    vecs[0] = '{1'b1, 8'b0000_1100, 0, 1'b0, 1'b0, 8'h0C};
    vecs[1] = '{1'b0, 8'b0111_0000, 2, 1'b1, 1'b0, 8'h0E};
    vecs[2] = '{1'b1, 8'b1010_0101, 1, 1'b1, 1'b0, 8'hA5};
    vecs[3] = '{1'b0, 8'b1100_0001, 0, 1'b0, 1'b0, 8'h83};
    vecs[4] = '{1'b1, 8'b1111_1111, 0, 1'b0, 1'b0, 8'hFF};
    vecs[5] = '{1'b0, 8'b0000_0001, 3, 1'b0, 1'b0, 8'h80};
    vecs[6] = '{1'b1, 8'b0000_1100, 0, 1'b0, 1'b1, 8'h0C};

    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_dout", dout, 8'h00);
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_perr", parity_err, 1'b0);

    dout_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      exp_perr = PAR ? vecs[v].pflip : 1'b0;
      sb_q.push_back({exp_perr, vecs[v].exp});
      send_seq(vecs[v].msb, vecs[v].seq, vecs[v].gap, vecs[v].toggle, 1'b1, vecs[v].pflip);
      chk("vec_valid", dout_valid, 1'b1);
      chk("vec_dout", dout, vecs[v].exp);
      chk("vec_perr", parity_err, exp_perr);
      step();
      chk("vec_valid_clr", dout_valid, 1'b0);
      chk("vec_dout_hold", dout, vecs[v].exp);
    end

    // Overrun: second word dropped while the first is still pending.
    dout_ready = 1'b0;
    sb_q.push_back({1'b0, 8'hA5});
    send_seq(1'b1, 8'hA5, 0, 1'b0, 1'b0, 1'b0);
    chk("ovr_valid", dout_valid, 1'b1);
    chk("ovr_dout_a5", dout, 8'hA5);
    chk("ovr_no_pulse", overrun, 1'b0);
    send_seq(1'b1, 8'h3C, 0, 1'b0, 1'b0, 1'b0);
    chk("ovr_pulse", overrun, 1'b1);
    chk("ovr_dout_kept", dout, 8'hA5);
    chk("ovr_valid_kept", dout_valid, 1'b1);
    step();
    chk("ovr_pulse_end", overrun, 1'b0);
    dout_ready = 1'b1;
    step();
    chk("ovr_drain_valid", dout_valid, 1'b0);
    chk("ovr_drain_dout", dout, 8'hA5);

    // Delivery and completion on the same edge.
    dout_ready = 1'b0;
    sb_q.push_back({1'b0, 8'h34});
    send_seq(1'b0, 8'b0010_1100, 1, 1'b0, 1'b0, 1'b0);
    chk("bb_first", dout, 8'h34);
    sb_q.push_back({1'b0, 8'h12});
    send_seq(1'b1, 8'h12, 0, 1'b0, 1'b1, 1'b0);
    chk("bb_dout", dout, 8'h12);
    chk("bb_valid", dout_valid, 1'b1);
    chk("bb_overrun", overrun, 1'b0);
    step();
    chk("bb_valid_clr", dout_valid, 1'b0);

    // Reset aborts a partial word and wins over sin_valid.
    msb_first = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    reset     = 1'b1;
    sin       = 1'b1;
    sin_valid = 1'b1;
    step();
    reset     = 1'b0;
    sin_valid = 1'b0;
    chk("abort_rst_valid", dout_valid, 1'b0);
    chk("abort_rst_dout", dout, 8'h00);
    sb_q.push_back({1'b0, 8'hFF});
    send_seq(1'b1, 8'hFF, 0, 1'b0, 1'b1, 1'b0);
    chk("abort_valid", dout_valid, 1'b1);
    chk("abort_dout", dout, 8'hFF);
    step();
    chk("abort_valid_clr", dout_valid, 1'b0);

    step();
    chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
